// File: rtl/payment_change_unit_if.sv
// Signal bundle between the payment/change unit and the machine front end
// (cost lookup, coin acceptor, change dispenser, serving sequencer).
interface payment_change_unit_if #(parameter int AMT_W = 5);
  logic [AMT_W-1:0] cost;
  logic             cost_valid;
  logic             coin_valid;
  logic [1:0]       coin_type;
  logic             cancel;
  logic             change_ack;
  logic [AMT_W-1:0] amount;
  logic             busy;
  logic             coin_reject;
  logic             paid;
  logic             change_valid;
  logic [1:0]       change_type;
  logic             done;

  modport master (
    output cost, cost_valid, coin_valid, coin_type, cancel, change_ack,
    input  amount, busy, coin_reject, paid, change_valid, change_type, done
  );

  modport slave (
    input  cost, cost_valid, coin_valid, coin_type, cancel, change_ack,
    output amount, busy, coin_reject, paid, change_valid, change_type, done
  );
endinterface

// File: rtl/payment_change_unit.sv
// Coin collection, payment detection and coin-by-coin change return for the
// coffee machine. All outputs come straight from registers.
module payment_change_unit #(
  parameter int AMT_W   = 5,
  parameter int MAX_AMT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  payment_change_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, COLLECT, PAID, CHANGE, DONE} state_t;

  localparam logic [AMT_W:0] MAX_EXT = (AMT_W+1)'(MAX_AMT);

  state_t           state_reg, state_next;
  logic [AMT_W-1:0] amount_reg, amount_next;
  logic [AMT_W-1:0] cost_q_reg, cost_q_next;
  logic [AMT_W-1:0] remaining_reg, remaining_next;
  logic             busy_reg, busy_next;
  logic             coin_reject_reg, coin_reject_next;
  logic             paid_reg, paid_next;
  logic             change_valid_reg, change_valid_next;
  logic [1:0]       change_type_reg, change_type_next;
  logic             done_reg, done_next;

  logic [AMT_W:0]   coin_sum;
  logic [AMT_W-1:0] change_left;
  logic [AMT_W-1:0] pay_diff;
  logic             coin_ok;
  logic             cost_ok;
  logic             covered;
  logic             change_taken;
  logic             coin_accept;

  function automatic logic [2:0] coin_value(input logic [1:0] t);
    case (t)
      2'b00:   coin_value = 3'd1;
      2'b01:   coin_value = 3'd2;
      2'b10:   coin_value = 3'd5;
      default: coin_value = 3'd0;
    endcase
  endfunction

  // Greedy change: the biggest coin that still fits in what is owed.
  function automatic logic [1:0] largest_coin(input logic [AMT_W-1:0] r);
    if (r >= AMT_W'(5))      largest_coin = 2'b10;
    else if (r >= AMT_W'(2)) largest_coin = 2'b01;
    else                     largest_coin = 2'b00;
  endfunction

  assign coin_sum     = (AMT_W+1)'(amount_reg) + (AMT_W+1)'(coin_value(bus.coin_type));
  assign coin_ok      = (bus.coin_type != 2'b11) && (coin_sum <= MAX_EXT);
  assign cost_ok      = bus.cost_valid && (bus.cost != '0) && ((AMT_W+1)'(bus.cost) <= MAX_EXT);
  assign covered      = (amount_reg >= cost_q_reg);
  assign pay_diff     = amount_reg - cost_q_reg;
  assign change_left  = remaining_reg - AMT_W'(coin_value(change_type_reg));
  assign change_taken = bus.change_ack && change_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      amount_reg       <= '0;
      cost_q_reg       <= '0;
      remaining_reg    <= '0;
      busy_reg         <= 1'b0;
      coin_reject_reg  <= 1'b0;
      paid_reg         <= 1'b0;
      change_valid_reg <= 1'b0;
      change_type_reg  <= 2'b00;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      amount_reg       <= amount_next;
      cost_q_reg       <= cost_q_next;
      remaining_reg    <= remaining_next;
      busy_reg         <= busy_next;
      coin_reject_reg  <= coin_reject_next;
      paid_reg         <= paid_next;
      change_valid_reg <= change_valid_next;
      change_type_reg  <= change_type_next;
      done_reg         <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cost_ok) state_next = COLLECT;
      COLLECT: begin
        if (bus.cancel)   state_next = (amount_reg != '0) ? CHANGE : DONE;
        else if (covered) state_next = PAID;
      end
      PAID:    state_next = (pay_diff != '0) ? CHANGE : DONE;
      CHANGE:  if (change_taken && change_left == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered-output next values; outputs track state_next
  // so each pulse lines up with the state it belongs to.
  always_comb begin
    amount_next    = amount_reg;
    cost_q_next    = cost_q_reg;
    remaining_next = remaining_reg;
    coin_accept    = 1'b0;
    case (state_reg)
      IDLE:    if (cost_ok) cost_q_next = bus.cost;
      COLLECT: begin
        if (bus.cancel) begin
          remaining_next = amount_reg;
          amount_next    = '0;
        end else if (!covered && bus.coin_valid && coin_ok) begin
          amount_next = coin_sum[AMT_W-1:0];
          coin_accept = 1'b1;
        end
      end
      PAID: begin
        remaining_next = pay_diff;
        amount_next    = '0;
      end
      CHANGE:  if (change_taken) remaining_next = change_left;
      DONE:    cost_q_next = '0;
      default: ;
    endcase
    coin_reject_next  = bus.coin_valid && !coin_accept;
    busy_next         = (state_next != IDLE);
    paid_next         = (state_next == PAID);
    change_valid_next = (state_next == CHANGE);
    done_next         = (state_next == DONE);
    change_type_next  = (state_next == CHANGE) ? largest_coin(remaining_next) : 2'b00;
  end

  assign bus.amount       = amount_reg;
  assign bus.busy         = busy_reg;
  assign bus.coin_reject  = coin_reject_reg;
  assign bus.paid         = paid_reg;
  assign bus.change_valid = change_valid_reg;
  assign bus.change_type  = change_type_reg;
  assign bus.done         = done_reg;

endmodule

// File: tb/tb_payment_change_unit.sv
// Bench for payment_change_unit: directed scenarios plus random transactions
// checked against a transaction-level model of coins, payment and change.
module tb_payment_change_unit;
  localparam int AMT_W   = 5;
  localparam int MAX_AMT = 31;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  payment_change_unit_if #(.AMT_W(AMT_W)) bus();

  payment_change_unit #(.AMT_W(AMT_W), .MAX_AMT(MAX_AMT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;
  logic [1:0] coin_q[$];

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int coin_val(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int code_of(input int v);
    if (v == 5) return 2;
    if (v == 2) return 1;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cost_valid = 1'b0;
    bus.coin_valid = 1'b0;
    bus.coin_type  = 2'b00;
    bus.cancel     = 1'b0;
    bus.change_ack = 1'b0;
  endtask

  task automatic start(input int c);
    bus.cost       = AMT_W'(c);
    bus.cost_valid = 1'b1;
    tick();
    bus.cost_valid = 1'b0;
    bus.cost       = AMT_W'($urandom);
    check("start_busy", bus.busy, 1);
    check("start_amount", bus.amount, 0);
  endtask

  // Plays one transaction with the coins in coin_q; the model decides from
  // plain arithmetic what is accepted, whether it pays, and the change owed.
  task automatic run_txn(input int cost_v, input int cancel_at, input bit cancel_coin,
                         input bit poke, input int hold);
    int  amt, v, owed, c, n_chg;
    bit  covered, cancelled, acc, cv;
    amt = 0; covered = 0; cancelled = 0; n_chg = 0;
    start(cost_v);
    for (int i = 0; i < coin_q.size(); i++) begin
      if (i == cancel_at) begin
        cancelled = 1;
        break;
      end
      v   = coin_val(coin_q[i]);
      acc = (v != 0) && (amt + v <= MAX_AMT);
      if (acc) amt += v;
      bus.coin_valid = 1'b1;
      bus.coin_type  = coin_q[i];
      tick();
      bus.coin_valid = 1'b0;
      check("coin_reject", bus.coin_reject, !acc);
      check("coin_amount", bus.amount, amt);
      if (amt >= cost_v) begin
        covered = 1;
        break;
      end
      if ($urandom_range(0, 2) == 0) begin
        tick();
        check("gap_reject", bus.coin_reject, 0);
        check("gap_amount", bus.amount, amt);
      end
    end
    if (covered) begin
      bus.coin_valid = poke;
      bus.coin_type  = 2'($urandom);
      tick();
      check("pay_paid", bus.paid, 1);
      check("pay_amount", bus.amount, amt);
      check("pay_reject", bus.coin_reject, poke);
      tick();
      bus.coin_valid = 1'b0;
      check("post_pay_paid", bus.paid, 0);
      check("post_pay_amount", bus.amount, 0);
      check("paid_cycle_reject", bus.coin_reject, poke);
      owed = amt - cost_v;
    end else begin
      bus.cancel     = 1'b1;
      bus.coin_valid = cancelled && cancel_coin;
      bus.coin_type  = 2'b10;
      tick();
      check("cancel_reject", bus.coin_reject, cancelled && cancel_coin);
      bus.cancel     = 1'b0;
      bus.coin_valid = 1'b0;
      check("cancel_paid", bus.paid, 0);
      check("cancel_amount", bus.amount, 0);
      owed = amt;
    end
    check("change_start", bus.change_valid, owed != 0);
    while (owed > 0) begin
      c = (owed >= 5) ? 5 : ((owed >= 2) ? 2 : 1);
      check("chg_valid", bus.change_valid, 1);
      check("chg_type", bus.change_type, code_of(c));
      check("chg_paid", bus.paid, 0);
      for (int h = 0; h < hold; h++) begin
        cv             = 1'($urandom_range(0, 1));
        bus.coin_valid = cv;
        bus.coin_type  = 2'($urandom);
        bus.cancel     = 1'($urandom_range(0, 1));
        bus.cost_valid = 1'($urandom_range(0, 1));
        tick();
        check("hold_valid", bus.change_valid, 1);
        check("hold_type", bus.change_type, code_of(c));
        check("hold_reject", bus.coin_reject, cv);
      end
      drive_idle();
      bus.change_ack = 1'b1;
      tick();
      bus.change_ack = 1'b0;
      owed -= c;
      n_chg++;
    end
    check("end_valid", bus.change_valid, 0);
    check("end_done", bus.done, 1);
    check("end_busy", bus.busy, 1);
    tick();
    check("idle_done", bus.done, 0);
    check("idle_busy", bus.busy, 0);
    n_txn++;
    $display("txn %0d: cost=%0d inserted=%0d paid=%0d change_coins=%0d", n_txn, cost_v, amt,
             covered, n_chg);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, cat;
    bus.cost = '0;
    drive_idle();
    rst = 1'b0;
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_amount", bus.amount, 0);
    check("rst_change_valid", bus.change_valid, 0);
    check("rst_change_type", bus.change_type, 0);
    check("rst_flags", {bus.paid, bus.done, bus.coin_reject}, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Coins while idle are returned; a zero cost does not start anything.
    bus.coin_valid = 1'b1;
    bus.coin_type  = 2'b10;
    tick();
    bus.coin_valid = 1'b0;
    check("idle_coin_reject", bus.coin_reject, 1);
    check("idle_coin_busy", bus.busy, 0);
    tick();
    check("idle_reject_pulse", bus.coin_reject, 0);
    bus.cost       = '0;
    bus.cost_valid = 1'b1;
    tick();
    bus.cost_valid = 1'b0;
    check("zero_cost_busy", bus.busy, 0);

    coin_q = '{2'b01, 2'b00};                 run_txn(3, -1, 0, 0, 0);
    coin_q = '{2'b10, 2'b10};                 run_txn(7, -1, 0, 0, 1);
    coin_q = '{2'b10};                        run_txn(1, -1, 0, 0, 4);
    coin_q = '{2'b01, 2'b00, 2'b00};          run_txn(9, 2, 0, 0, 0);
    coin_q = '{2'b01, 2'b00, 2'b00};          run_txn(9, 2, 1, 0, 0);
    coin_q = '{2'b00};                        run_txn(4, 0, 0, 0, 0);
    coin_q = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
    run_txn(31, -1, 0, 1, 0);

    // Reset in the middle of returning change.
    start(2);
    bus.coin_valid = 1'b1;
    bus.coin_type  = 2'b10;
    tick();
    bus.coin_valid = 1'b0;
    check("mid_amount", bus.amount, 5);
    tick();
    check("mid_paid", bus.paid, 1);
    tick();
    check("mid_chg_type", bus.change_type, 1);
    bus.change_ack = 1'b1;
    tick();
    bus.change_ack = 1'b0;
    check("mid_chg_type2", bus.change_type, 0);
    check("mid_chg_valid", bus.change_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_busy", bus.busy, 0);
    check("async_change_valid", bus.change_valid, 0);
    check("async_amount", bus.amount, 0);
    check("async_flags", {bus.paid, bus.done, bus.coin_reject, bus.change_type}, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("after_rst_busy", bus.busy, 0);
    coin_q = '{2'b00};                        run_txn(1, -1, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(1, 10);
      coin_q.delete();
      for (int k = 0; k < n; k++) coin_q.push_back(2'($urandom));
      cat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_txn($urandom_range(1, MAX_AMT), cat, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
